// File: rtl/wram_share_arbiter_pkg.sv
// wram_share_arbiter_pkg: window constants, arbitration/FSM types and port-index width helper
package wram_share_arbiter_pkg;
  localparam logic [15:0] WRAM_BASE = 16'h6000;
  localparam int WRAM_DEPTH = 8192;
  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  function automatic int port_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wram_arb_picker.sv
// wram_arb_picker: combinational winner select with override, fixed-priority and round-robin search
module wram_arb_picker
  import wram_share_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int PORT_W = port_w(N_PORTS)
) (
  input  logic [N_PORTS-1:0] eligible,
  input  logic [PORT_W-1:0]  last_grant,
  input  logic               override_valid,
  input  logic [PORT_W-1:0]  override_port,
  input  arb_mode_t          mode,
  output logic [PORT_W-1:0]  winner,
  output logic               found
);
  localparam int EW = 2 ** PORT_W;
  logic [EW-1:0] elig_pad;
  logic [PORT_W-1:0] cand;
  // zero padding makes override ports beyond N_PORTS-1 read as ineligible
  assign elig_pad = EW'(eligible);
  always_comb begin
    winner = '0;
    cand = '0;
    found = |eligible;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      cand = PORT_W'((mode == ARB_RR ? int'(last_grant) + 1 + k : k) % N_PORTS);
      winner = elig_pad[cand] ? cand : winner;
    end
    winner = override_valid && elig_pad[override_port] ? override_port : winner;
  end
endmodule

// File: rtl/wram_share_arbiter.sv
// wram_share_arbiter: N-port req/ack arbiter owning a byte-enabled BSRAM window; misses go to SDRAM
module wram_share_arbiter
  import wram_share_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(WRAM_BASE),
  parameter int DEPTH = WRAM_DEPTH,
  parameter int ARB_MODE = 0,
  localparam int PORT_W = port_w(N_PORTS)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [N_PORTS-1:0]          i_req,
  input  logic [N_PORTS-1:0]          i_we,
  input  logic [N_PORTS*ADDR_W-1:0]   i_addr,
  input  logic [N_PORTS*DATA_W-1:0]   i_wdata,
  input  logic [N_PORTS*DATA_W/8-1:0] i_be,
  input  logic                        i_override_valid,
  input  logic [PORT_W-1:0]           i_override_port,
  output logic [N_PORTS-1:0]          o_ack,
  output logic [DATA_W-1:0]           o_rdata,
  output logic [N_PORTS-1:0]          o_miss,
  output logic                        o_busy,
  output logic [PORT_W-1:0]           o_grant_port
);
  localparam int IW = $clog2(DEPTH);
  localparam int BW = DATA_W / 8;
  localparam logic [ADDR_W:0] LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] HI = LO + (ADDR_W + 1)'(DEPTH);
  state_t state;
  logic [N_PORTS-1:0] hit;
  logic [IW-1:0] idx [N_PORTS];
  logic [PORT_W-1:0] last_grant, winner;
  logic found, we_q;
  logic [IW-1:0] idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BW-1:0] be_q;
  logic [DATA_W-1:0] mem [DEPTH];
  for (genvar p = 0; p < N_PORTS; p++) begin : g_dec
    logic [ADDR_W-1:0] a;
    assign a = i_addr[p*ADDR_W +: ADDR_W];
    assign hit[p] = {1'b0, a} >= LO && {1'b0, a} < HI;
    assign idx[p] = IW'(a - BASE_ADDR);
  end
  assign o_miss = i_req & ~hit;
  wram_arb_picker #(.N_PORTS(N_PORTS), .PORT_W(PORT_W)) u_picker (
    .eligible      (i_req & hit),
    .last_grant    (last_grant),
    .override_valid(i_override_valid),
    .override_port (i_override_port),
    .mode          (ARB_MODE == 1 ? ARB_RR : ARB_FIXED),
    .winner        (winner),
    .found         (found)
  );
  // block-RAM style byte-lane write; one write per grant, never while reset is held
  always_ff @(posedge i_clk)
    if (!i_reset && state == ACCESS && we_q)
      for (int b = 0; b < BW; b++)
        if (be_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state        <= IDLE;
      o_ack        <= '0;
      o_rdata      <= '0;
      o_busy       <= 1'b0;
      o_grant_port <= '0;
      last_grant   <= PORT_W'(N_PORTS - 1);
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else
      case (state)
        IDLE: if (found) begin
          state        <= ACCESS;
          o_busy       <= 1'b1;
          o_grant_port <= winner;
          last_grant   <= winner;
          we_q         <= i_we[winner];
          idx_q        <= idx[winner];
          wdata_q      <= i_wdata[winner*DATA_W +: DATA_W];
          be_q         <= i_be[winner*BW +: BW];
        end
        ACCESS: begin
          state   <= ACK;
          o_ack   <= N_PORTS'(1) << o_grant_port;
          o_rdata <= we_q ? o_rdata : mem[idx_q];
        end
        default: begin
          state  <= IDLE;
          o_ack  <= '0;
          o_busy <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_wram_share_arbiter.sv
// tb_wram_share_arbiter: scoreboard bench for a fixed-priority 16-bit and a round-robin 8-bit instance
`timescale 1ns/1ps
module tb_wram_share_arbiter;
  import wram_share_arbiter_pkg::*;
  typedef struct {int port; logic [15:0] rd; int due;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0, vectors = 0, miscompares = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [1:0] req [2], we [2], acked [2];
  logic [15:0] addr [2][2], wdata [2][2];
  logic [1:0] be [2][2];
  logic ovr_v [2], ovr_p [2];
  logic [1:0] ack0, ack1, miss0, miss1;
  logic [15:0] a_rdata;
  logic [7:0] b_rdata;
  logic busy0, busy1, gp0, gp1;
  logic [15:0] mdl [2][8192];
  int last_g [2];
  logic [15:0] last_rd [2];
  exp_t sb [2][$];
  logic [15:0] pool [8];

  wram_share_arbiter #(.N_PORTS(2), .ADDR_W(16), .DATA_W(16), .BASE_ADDR(16'h6000), .DEPTH(8192), .ARB_MODE(0)) u_fix (
    .i_clk(clk), .i_reset(rst), .i_req(req[0]), .i_we(we[0]),
    .i_addr({addr[0][1], addr[0][0]}), .i_wdata({wdata[0][1], wdata[0][0]}), .i_be({be[0][1], be[0][0]}),
    .i_override_valid(ovr_v[0]), .i_override_port(ovr_p[0]),
    .o_ack(ack0), .o_rdata(a_rdata), .o_miss(miss0), .o_busy(busy0), .o_grant_port(gp0));
  wram_share_arbiter #(.N_PORTS(2), .ADDR_W(16), .DATA_W(8), .BASE_ADDR(16'h6000), .DEPTH(8192), .ARB_MODE(1)) u_rr (
    .i_clk(clk), .i_reset(rst), .i_req(req[1]), .i_we(we[1]),
    .i_addr({addr[1][1], addr[1][0]}), .i_wdata({wdata[1][1][7:0], wdata[1][0][7:0]}), .i_be({be[1][1][0], be[1][0][0]}),
    .i_override_valid(ovr_v[1]), .i_override_port(ovr_p[1]),
    .o_ack(ack1), .o_rdata(b_rdata), .o_miss(miss1), .o_busy(busy1), .o_grant_port(gp1));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [15:0] a);
    return int'(a) >= 'h6000 && int'(a) < 'h6000 + 8192;
  endfunction

  function automatic int widx(input logic [15:0] a);
    return int'(a) - 'h6000;
  endfunction

  task automatic setp(input int d, input int p, input bit w, input logic [15:0] a, input logic [15:0] wd, input logic [1:0] b);
    we[d][p] = w;
    addr[d][p] = a;
    wdata[d][p] = wd;
    be[d][p] = b;
  endtask

  task automatic model_reset();
    last_g = '{1, 1};
    last_rd = '{16'h0, 16'h0};
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    logic [1:0] a;
    logic [15:0] r;
    logic g;
    for (int d = 0; d < 2; d++) begin
      a = d == 1 ? ack1 : ack0;
      r = d == 1 ? {8'h00, b_rdata} : a_rdata;
      g = d == 1 ? gp1 : gp0;
      if (a != 2'b00) begin
        if (sb[d].size() == 0) chk($sformatf("dut%0d unexpected ack", d), 32'(a), 32'd0);
        else begin
          e = sb[d].pop_front();
          chk($sformatf("dut%0d ack vector", d), 32'(a), 32'(2'b01 << e.port));
          chk($sformatf("dut%0d grant port", d), 32'(g), 32'(e.port));
          chk($sformatf("dut%0d rdata", d), 32'(r), 32'(e.rd));
          chk($sformatf("dut%0d ack cycle", d), cyc, e.due);
          acked[d] = acked[d] | a;
        end
      end
    end
  end

  // all requesters raise together; the model orders service from the arbitration rules
  task automatic round(input int d, input logic [1:0] rq, input bit ov, input bit op);
    logic [1:0] hitv, left;
    logic [15:0] m;
    int w, issue, k;
    for (int p = 0; p < 2; p++) hitv[p] = in_win(addr[d][p]);
    @(posedge clk); #1;
    issue = cyc;
    req[d] = rq;
    ovr_v[d] = ov;
    ovr_p[d] = op;
    acked[d] = 2'b00;
    left = rq & hitv;
    m = d == 1 ? 16'h00FF : 16'hFFFF;
    k = 0;
    while (left != 2'b00) begin
      w = -1;
      if (ov && left[op]) w = int'(op);
      for (int s = 0; s < 2; s++) begin
        int c = d == 1 ? (last_g[d] + 1 + s) % 2 : s;
        if (w < 0 && left[c]) w = c;
      end
      if (we[d][w]) begin
        for (int b = 0; b < 2; b++)
          if (be[d][w][b] && m[b*8]) mdl[d][widx(addr[d][w])][b*8 +: 8] = wdata[d][w][b*8 +: 8];
      end else last_rd[d] = mdl[d][widx(addr[d][w])];
      sb[d].push_back('{w, last_rd[d], issue + 2 + 3 * k});
      last_g[d] = w;
      left[w] = 1'b0;
      k++;
    end
    @(negedge clk);
    chk($sformatf("dut%0d miss", d), 32'(d == 1 ? miss1 : miss0), 32'(rq & ~hitv));
    for (int n = 0; n < 14; n++) begin
      @(posedge clk); #1;
      req[d] = req[d] & ~acked[d];
      acked[d] = 2'b00;
      if (sb[d].size() == 0 && n >= 3) break;
    end
    if (sb[d].size() != 0) begin
      chk($sformatf("dut%0d acks outstanding at timeout", d), 32'(sb[d].size()), 32'd0);
      sb[d].delete();
    end
    req[d] = 2'b00;
    ovr_v[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 2'b00;
      acked[d] = 2'b00;
      ovr_v[d] = 1'b0;
      ovr_p[d] = 1'b0;
      for (int p = 0; p < 2; p++) setp(d, p, 1'b0, 16'h6000, 16'h0, 2'b00);
      for (int i = 0; i < 8192; i++) mdl[d][i] = 16'h0;
    end
    model_reset();
    pool[0] = 16'h6000;
    pool[1] = 16'h6010;
    pool[2] = 16'h7000;
    pool[3] = 16'h7FFF;
    for (int i = 4; i < 8; i++) pool[i] = 16'h6000 + 16'($urandom_range(0, 8191));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle busy0", 32'(busy0), 32'd0);
      chk("idle busy1", 32'(busy1), 32'd0);
      chk("idle ack0", 32'(ack0), 32'd0);
    end
    chk("reset rdata0", 32'(a_rdata), 32'd0);
    chk("reset grant1", 32'(gp1), 32'd0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) begin
        setp(d, 0, 1'b1, pool[i], 16'($urandom), 2'b11);
        round(d, 2'b01, 1'b0, 1'b0);
      end
    setp(1, 0, 1'b1, 16'h6000, 16'h00A5, 2'b01);
    round(1, 2'b01, 1'b0, 1'b0);
    setp(1, 1, 1'b0, 16'h6000, 16'h0, 2'b00);
    round(1, 2'b10, 1'b0, 1'b0);
    setp(0, 0, 1'b0, 16'h5FFF, 16'h0, 2'b11);
    setp(0, 1, 1'b1, 16'h8000, 16'h5555, 2'b11);
    round(0, 2'b11, 1'b0, 1'b0);
    setp(0, 0, 1'b0, 16'h7FFF, 16'h0, 2'b00);
    round(0, 2'b01, 1'b0, 1'b0);
    setp(0, 0, 1'b1, 16'h7000, 16'h1111, 2'b11);
    setp(0, 1, 1'b0, 16'h7000, 16'h0, 2'b00);
    round(0, 2'b11, 1'b0, 1'b0);
    setp(0, 0, 1'b1, 16'h7000, 16'h2222, 2'b11);
    round(0, 2'b11, 1'b1, 1'b1);
    setp(1, 0, 1'b0, 16'h6000, 16'h0, 2'b00);
    setp(1, 1, 1'b0, 16'h6000, 16'h0, 2'b00);
    round(1, 2'b11, 1'b0, 1'b0);
    round(1, 2'b11, 1'b0, 1'b0);
    round(1, 2'b01, 1'b0, 1'b0);
    round(1, 2'b11, 1'b0, 1'b0);
    setp(0, 0, 1'b1, 16'h6010, 16'h1234, 2'b11);
    round(0, 2'b01, 1'b0, 1'b0);
    setp(0, 0, 1'b1, 16'h6010, 16'hABCD, 2'b10);
    round(0, 2'b01, 1'b0, 1'b0);
    setp(0, 1, 1'b0, 16'h6010, 16'h0, 2'b00);
    round(0, 2'b10, 1'b0, 1'b0);
    // reset lands while the 16'hFFFF write sits in ACCESS
    setp(0, 1, 1'b1, 16'h6010, 16'hFFFF, 2'b11);
    @(posedge clk); #1;
    req[0] = 2'b10;
    @(posedge clk);
    @(negedge clk);
    chk("busy before reset", 32'(busy0), 32'd1);
    chk("rdata before reset", 32'(a_rdata), 32'(last_rd[0]));
    rst = 1'b1;
    #1;
    chk("async reset busy", 32'(busy0), 32'd0);
    chk("async reset ack", 32'(ack0), 32'd0);
    chk("async reset rdata", 32'(a_rdata), 32'd0);
    chk("async reset grant", 32'(gp0), 32'd0);
    req[0] = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post reset busy", 32'(busy0), 32'd0);
    setp(0, 0, 1'b0, 16'h6010, 16'h0, 2'b00);
    round(0, 2'b01, 1'b0, 1'b0);
    for (int r = 0; r < 40; r++)
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          logic [15:0] a;
          a = $urandom_range(0, 7) == 0
              ? ($urandom_range(0, 1) == 1 ? 16'h5FFF - 16'($urandom_range(0, 255)) : 16'h8000 + 16'($urandom_range(0, 4095)))
              : pool[$urandom_range(0, 7)];
          setp(d, p, 1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)));
        end
        round(d, 2'($urandom_range(1, 3)), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
